// File: rtl/mxint8_pkg.sv
// Shared MXINT8 / binary32 widths, constants and types for the block-sum datapath and its reference model.
package mxint8_pkg;

   localparam int SCALE_WIDTH          = 8;
   localparam int MXINT8_ELEMENT_WIDTH = 8;
   localparam int FLOAT32_WIDTH        = 32;
   localparam int MXINT8_BLOCK_SIZE    = 32;
   localparam int ACC_WIDTH            = 14;

   localparam int E8M0_BIAS      = 127;
   localparam int FP32_BIAS      = 127;
   localparam int ELEM_FRAC_BITS = 6;

   localparam logic [SCALE_WIDTH-1:0]   SCALE_NAN = 8'hFF;
   localparam logic [FLOAT32_WIDTH-1:0] FP32_QNAN = 32'h7FC0_0000;

   typedef logic        [SCALE_WIDTH-1:0]          scale_t;
   typedef logic signed [MXINT8_ELEMENT_WIDTH-1:0] element_t;
   typedef logic        [FLOAT32_WIDTH-1:0]        float32_t;
   typedef logic signed [ACC_WIDTH-1:0]            acc_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      PACK  = 2'd2,
      OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/mxint8_fp32_pack.sv
// Combinational {E8M0 scale, 14-bit element sum} -> binary32 plus unused/underflow flags.
// MXINT8_BLOCK_SUM_FTZ_EN: flush subnormal results to +0 (underflow flag still set).
module mxint8_fp32_pack
   import mxint8_pkg::*;
(
   input  scale_t   scale,
   input  acc_t     sum,
   output float32_t fp32,
   output logic     unused_flag,
   output logic     underflow_flag
);

   // Biased fp32 exponent = scale - E8M0_BIAS - ELEM_FRAC_BITS + FP32_BIAS + msb_pos.
   localparam logic signed [10:0] EXP_ADJ = 11'(E8M0_BIAS + ELEM_FRAC_BITS - FP32_BIAS);

   logic                  sign;
   logic [ACC_WIDTH-1:0]  mag;
   logic [3:0]            msb_pos;
   logic signed [10:0]    exp_b;
   logic [22:0]           frac_norm;
   logic [22:0]           frac_sub;

   always_comb begin
      sign    = sum[ACC_WIDTH-1];
      mag     = sign ? ACC_WIDTH'(-sum) : ACC_WIDTH'(sum);
      msb_pos = 4'd0;
      for (int i = 0; i < ACC_WIDTH; i++) begin
         if (mag[i]) msb_pos = 4'(i);
      end
      exp_b     = $signed({3'b000, scale}) + $signed({7'b0, msb_pos}) - EXP_ADJ;
      // Shifting within 23 bits drops the implicit leading one.
      frac_norm = {9'b0, mag} << (5'd23 - {1'b0, msb_pos});
      // Only used when exp_b <= 0, i.e. scale <= 6, so the shift is exact.
      frac_sub  = {9'b0, mag} << ({1'b0, scale} + 9'd16);
   end

   always_comb begin
      fp32           = '0;
      unused_flag    = 1'b0;
      underflow_flag = 1'b0;
      if (scale == SCALE_NAN) begin
         fp32        = FP32_QNAN;
         unused_flag = 1'b1;
      end else if (sum == '0) begin
         fp32 = '0;
      end else if (exp_b >= 11'sd255) begin
         // Large scales exceed binary32 range: saturate to signed infinity.
         fp32 = {sign, 8'hFF, 23'b0};
      end else if (exp_b >= 11'sd1) begin
         fp32 = {sign, exp_b[7:0], frac_norm};
      end else begin
         underflow_flag = 1'b1;
`ifdef MXINT8_BLOCK_SUM_FTZ_EN
         fp32 = '0;
`else
         fp32 = {sign, 8'h00, frac_sub};
`endif
      end
   end

endmodule

// File: rtl/mxint8_block_sum.sv
// Reduces one MXINT8 block (E8M0 scale + BLOCK_SIZE int8) to a binary32 sum; latency BLOCK_SIZE/LANES+1 cycles.
// Accepts only in IDLE, holds result in OUT until out_ready; no block overlap. Subnormal FTZ via MXINT8_BLOCK_SUM_FTZ_EN.
module mxint8_block_sum
   import mxint8_pkg::*;
#(
   parameter int BLOCK_SIZE = MXINT8_BLOCK_SIZE,
   parameter int LANES      = 4
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic [SCALE_WIDTH-1:0]                     in_scale,
   input  logic [BLOCK_SIZE*MXINT8_ELEMENT_WIDTH-1:0] in_elements,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [FLOAT32_WIDTH-1:0]                   out_sum,
   output logic                                       out_unused_flag,
   output logic                                       out_underflow_flag
);

   localparam int NBEATS = BLOCK_SIZE / LANES;
   localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int EW     = MXINT8_ELEMENT_WIDTH;

   state_t                      state, state_nxt;
   scale_t                      scale_q;
   logic [BLOCK_SIZE*EW-1:0]    elems_q;
   acc_t                        acc;
   acc_t                        lane_sum;
   logic [CNT_W-1:0]            cnt;
   logic                        last_beat;
   float32_t                    pack_sum;
   logic                        pack_unused;
   logic                        pack_underflow;

   assign last_beat = (cnt == CNT_W'(NBEATS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = ACCUM;
         ACCUM:   if (last_beat) state_nxt = PACK;
         PACK:                   state_nxt = OUT;
         OUT:     if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == OUT);
   end

   // The lowest LANES elements of elems_q are always the next ones in index order.
   always_comb begin
      lane_sum = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_sum = lane_sum + acc_t'($signed(elems_q[l*EW +: EW]));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scale_q <= '0;
         elems_q <= '0;
         acc     <= '0;
         cnt     <= '0;
      end else if (state == IDLE && in_valid) begin
         scale_q <= in_scale;
         elems_q <= in_elements;
         acc     <= '0;
         cnt     <= '0;
      end else if (state == ACCUM) begin
         elems_q <= elems_q >> (LANES * EW);
         acc     <= acc + lane_sum;
         cnt     <= cnt + 1'b1;
      end
   end

   mxint8_fp32_pack u_pack (
      .scale          (scale_q),
      .sum            (acc),
      .fp32           (pack_sum),
      .unused_flag    (pack_unused),
      .underflow_flag (pack_underflow)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_sum            <= '0;
         out_unused_flag    <= 1'b0;
         out_underflow_flag <= 1'b0;
      end else if (state == PACK) begin
         out_sum            <= pack_sum;
         out_unused_flag    <= pack_unused;
         out_underflow_flag <= pack_underflow;
      end
   end

endmodule
